// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//
// Single-clock FIFO with programmable almost-full / almost-empty thresholds,
// a registered read port (one cycle of read latency) and registered
// per-request handshake / error pulses.
//
// Parameters
//   FIFO_WIDTH  data word width in bits (>= 1)
//   FIFO_DEPTH  number of storage entries (>= 2, any value)
//   AF_MARGIN   almostfull asserts when free entries <= AF_MARGIN
//   AE_MARGIN   almostempty asserts when occupancy <= AE_MARGIN
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   data_in      write data, stored when a write is accepted
//   wr_en        write request, accepted only while not full
//   rd_en        read request, accepted only while not empty
//   data_out     registered read data, holds between accepted reads
//   rd_valid     one-cycle pulse: data_out was loaded by the last edge
//   wr_ack       one-cycle pulse: previous-cycle write was accepted
//   overflow     one-cycle pulse: previous-cycle write rejected (full)
//   underflow    one-cycle pulse: previous-cycle read rejected (empty)
//   full         count == FIFO_DEPTH
//   empty        count == 0
//   almostfull   count >= FIFO_DEPTH-AF_MARGIN and not full
//   almostempty  count <= AE_MARGIN and not empty
//   count        current occupancy
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [FIFO_WIDTH-1:0]            data_in,
    input  logic                             wr_en,
    input  logic                             rd_en,
    output logic [FIFO_WIDTH-1:0]            data_out,
    output logic                             rd_valid,
    output logic                             wr_ack,
    output logic                             overflow,
    output logic                             underflow,
    output logic                             full,
    output logic                             empty,
    output logic                             almostfull,
    output logic                             almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

    // Pointer width covers indices 0..FIFO_DEPTH-1; the depth need not be a
    // power of two, so pointers wrap explicitly rather than by overflow.
    localparam int PTR_W = ($clog2(FIFO_DEPTH) < 1) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(AE_MARGIN);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Status flags are pure functions of the occupancy counter so they track
    // count immediately, including while reset is held.
    always_comb begin
        full        = (count == DEPTH_C);
        empty       = (count == '0);
        almostfull  = (count >= AF_LEVEL) && (count != DEPTH_C);
        almostempty = (count <= AE_LEVEL) && (count != '0);
    end

    // Acceptance depends only on the current flags: a read can free a slot
    // this cycle but never makes a write to a full FIFO legal, and a write
    // never makes a read from an empty FIFO legal.
    always_comb begin
        wr_accept = wr_en && !full;
        rd_accept = rd_en && !empty;
    end

    // Storage array is deliberately left unreset; contents are unreachable
    // after reset because the FIFO reports empty until new data is written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Write and read pointers move only on accepted requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
        end
    end

    // Occupancy: simultaneous accepted read and write cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered read port: data_out is loaded from the head entry on an
    // accepted read and otherwise keeps the last word delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_accept) begin
            data_out <= mem[rd_ptr];
        end
    end

    // Handshake and error pulses are rewritten every cycle, so each one is
    // high for exactly the cycle after the request that caused it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= rd_accept;
            wr_ack    <= wr_accept;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_prog
//
// Self-checking bench for sync_fifo_prog (WIDTH=16, DEPTH=8, margins 1).
// A queue-based reference model tracks the FIFO contents and expected pulse
// outputs; each test task drives its scenario and compares inline.
// ---------------------------------------------------------------------------
module tb_sync_fifo_prog;

    localparam int W     = 16;
    localparam int D     = 8;
    localparam int AF    = 1;
    localparam int AE    = 1;
    localparam int CW    = $clog2(D + 1);

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  data_out;
    logic          rd_valid;
    logic          wr_ack;
    logic          overflow;
    logic          underflow;
    logic          full;
    logic          empty;
    logic          almostfull;
    logic          almostempty;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_dout;
    logic         exp_rv;
    logic         exp_ack;
    logic         exp_ovf;
    logic         exp_unf;

    sync_fifo_prog #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .AF_MARGIN  (AF),
        .AE_MARGIN  (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (count)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model reset: discard everything, registered outputs return to zero.
    task automatic model_reset();
        model_q.delete();
        exp_dout = '0;
        exp_rv   = 1'b0;
        exp_ack  = 1'b0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // Drive one cycle of requests at the falling edge, advance the model by
    // the FIFO rules, then wait until just after the rising edge.
    task automatic do_cycle(input logic wr, input logic rd, input logic [W-1:0] d);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        data_in = d;
        was_full  = (model_q.size() == D);
        was_empty = (model_q.size() == 0);
        exp_ack = wr && !was_full;
        exp_ovf = wr && was_full;
        exp_rv  = rd && !was_empty;
        exp_unf = rd && was_empty;
        if (exp_rv) exp_dout = model_q.pop_front();
        if (exp_ack) model_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count, empty, full, almostfull, almostempty} !== {CW'(0), 4'b1000}) begin
            errors++;
            $display("[TB] FAIL reset_status: got count=%0d e=%b f=%b af=%b ae=%b expected count=0 e=1 f=0 af=0 ae=0",
                     count, empty, full, almostfull, almostempty);
        end
        checks++;
        if ({data_out, rd_valid, wr_ack, overflow, underflow} !== {W'(0), 4'b0000}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got dout=%h rv=%b ack=%b ovf=%b unf=%b expected all zero",
                     data_out, rd_valid, wr_ack, overflow, underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b0, 1'b0, '0);
        checks++;
        if ({count, empty, full, almostfull, almostempty} !== {CW'(0), 4'b1000}) begin
            errors++;
            $display("[TB] FAIL post_reset_status: got count=%0d e=%b f=%b af=%b ae=%b expected count=0 e=1 f=0 af=0 ae=0",
                     count, empty, full, almostfull, almostempty);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            do_cycle(1'b1, 1'b0, W'(i));
            checks++;
            if (wr_ack !== 1'b1 || overflow !== 1'b0 || count !== CW'(i)) begin
                errors++;
                $display("[TB] FAIL fill_write%0d: got ack=%b ovf=%b count=%0d expected ack=1 ovf=0 count=%0d",
                         i, wr_ack, overflow, count, i);
            end
            checks++;
            if (almostfull !== (i == D - 1) || full !== (i == D)) begin
                errors++;
                $display("[TB] FAIL fill_flags%0d: got af=%b f=%b expected af=%b f=%b",
                         i, almostfull, full, (i == D - 1), (i == D));
            end
        end
        do_cycle(1'b1, 1'b0, 16'hDEAD);
        checks++;
        if (overflow !== 1'b1 || wr_ack !== 1'b0 || count !== CW'(D) || full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fill_overflow: got ovf=%b ack=%b count=%0d f=%b expected ovf=1 ack=0 count=%0d f=1",
                     overflow, wr_ack, count, full, D);
        end
        do_cycle(1'b0, 1'b0, '0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_pulse: got ovf=%b expected 0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= D; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            checks++;
            if (rd_valid !== 1'b1 || data_out !== W'(i) || count !== CW'(D - i)) begin
                errors++;
                $display("[TB] FAIL drain_read%0d: got rv=%b dout=%h count=%0d expected rv=1 dout=%h count=%0d",
                         i, rd_valid, data_out, count, W'(i), D - i);
            end
            checks++;
            if (almostempty !== (i == D - 1) || empty !== (i == D)) begin
                errors++;
                $display("[TB] FAIL drain_flags%0d: got ae=%b e=%b expected ae=%b e=%b",
                         i, almostempty, empty, (i == D - 1), (i == D));
            end
        end
        do_cycle(1'b0, 1'b1, '0);
        checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || data_out !== 16'h0008 || count !== CW'(0)) begin
            errors++;
            $display("[TB] FAIL drain_underflow: got unf=%b rv=%b dout=%h count=%0d expected unf=1 rv=0 dout=0008 count=0",
                     underflow, rd_valid, data_out, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] next_val;
        next_val = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, next_val);
            next_val++;
        end
        checks++;
        if (count !== CW'(4)) begin
            errors++;
            $display("[TB] FAIL b2b_prefill: got count=%0d expected 4", count);
        end
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 1'b1, next_val);
            next_val++;
            checks++;
            if (count !== CW'(4) || rd_valid !== 1'b1 || wr_ack !== 1'b1 || data_out !== W'(16'h0100 + i)) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: got count=%0d rv=%b ack=%b dout=%h expected count=4 rv=1 ack=1 dout=%h",
                         i, count, rd_valid, wr_ack, data_out, W'(16'h0100 + i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== exp_dout || data_out !== W'(16'h0114 + i)) begin
                errors++;
                $display("[TB] FAIL b2b_drain%0d: got dout=%h expected %h", i, data_out, W'(16'h0114 + i));
            end
        end
    endtask

    task automatic test_empty_both();
        do_cycle(1'b1, 1'b1, 16'h00AA);
        checks++;
        if (underflow !== 1'b1 || wr_ack !== 1'b1 || rd_valid !== 1'b0 || count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL empty_both: got unf=%b ack=%b rv=%b count=%0d expected unf=1 ack=1 rv=0 count=1",
                     underflow, wr_ack, rd_valid, count);
        end
        do_cycle(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 16'h00AA || rd_valid !== 1'b1 || underflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL empty_both_read: got dout=%h rv=%b unf=%b e=%b expected dout=00aa rv=1 unf=0 e=1",
                     data_out, rd_valid, underflow, empty);
        end
    endtask

    task automatic test_full_both();
        for (int i = 0; i < D; i++) do_cycle(1'b1, 1'b0, W'(16'h0200 + i));
        do_cycle(1'b1, 1'b1, 16'hBEEF);
        checks++;
        if (overflow !== 1'b1 || wr_ack !== 1'b0 || rd_valid !== 1'b1 || data_out !== 16'h0200 || count !== CW'(D - 1)) begin
            errors++;
            $display("[TB] FAIL full_both: got ovf=%b ack=%b rv=%b dout=%h count=%0d expected ovf=1 ack=0 rv=1 dout=0200 count=%0d",
                     overflow, wr_ack, rd_valid, data_out, count, D - 1);
        end
        for (int i = 1; i < D; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== W'(16'h0200 + i)) begin
                errors++;
                $display("[TB] FAIL full_both_drain%0d: got dout=%h expected %h", i, data_out, W'(16'h0200 + i));
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, W'(16'h0300 + i));
        do_cycle(1'b0, 1'b1, '0);
        do_cycle(1'b1, 1'b0, 16'h0305);
        checks++;
        if (count !== CW'(5)) begin
            errors++;
            $display("[TB] FAIL areset_prefill: got count=%0d expected 5", count);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({count, empty, full, almostfull, almostempty} !== {CW'(0), 4'b1000}) begin
            errors++;
            $display("[TB] FAIL areset_status: got count=%0d e=%b f=%b af=%b ae=%b expected count=0 e=1 f=0 af=0 ae=0",
                     count, empty, full, almostfull, almostempty);
        end
        checks++;
        if ({data_out, rd_valid, wr_ack, overflow, underflow} !== {W'(0), 4'b0000}) begin
            errors++;
            $display("[TB] FAIL areset_outputs: got dout=%h rv=%b ack=%b ovf=%b unf=%b expected all zero",
                     data_out, rd_valid, wr_ack, overflow, underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b1, 1'b0, 16'h1234);
        do_cycle(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 16'h1234 || rd_valid !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_first_word: got dout=%h rv=%b e=%b expected dout=1234 rv=1 e=1",
                     data_out, rd_valid, empty);
        end
    endtask

    task automatic test_random();
        int wr_pct;
        int rd_pct;
        int sz;
        for (int i = 0; i < 600; i++) begin
            // Shift the write/read bias every 100 cycles to visit full,
            // empty and mid-range occupancy.
            case ((i / 100) % 3)
                0:       begin wr_pct = 80; rd_pct = 30; end
                1:       begin wr_pct = 30; rd_pct = 80; end
                default: begin wr_pct = 60; rd_pct = 60; end
            endcase
            do_cycle($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct, W'($urandom));
            sz = model_q.size();
            checks++;
            if ({rd_valid, wr_ack, overflow, underflow} !== {exp_rv, exp_ack, exp_ovf, exp_unf}) begin
                errors++;
                $display("[TB] FAIL rand_pulses%0d: got rv/ack/ovf/unf=%b%b%b%b expected %b%b%b%b",
                         i, rd_valid, wr_ack, overflow, underflow, exp_rv, exp_ack, exp_ovf, exp_unf);
            end
            checks++;
            if (data_out !== exp_dout || count !== CW'(sz)) begin
                errors++;
                $display("[TB] FAIL rand_data%0d: got dout=%h count=%0d expected dout=%h count=%0d",
                         i, data_out, count, exp_dout, sz);
            end
            checks++;
            if (full !== (sz == D) || empty !== (sz == 0) ||
                almostfull !== ((D - sz) <= AF && sz < D) ||
                almostempty !== (sz <= AE && sz > 0)) begin
                errors++;
                $display("[TB] FAIL rand_flags%0d: got f=%b e=%b af=%b ae=%b for occupancy %0d",
                         i, full, empty, almostfull, almostempty, sz);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        $display("[TB] starting sync_fifo_prog bench");
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_empty_both();
        test_full_both();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, storage entries (>=2, power of two not required).
REQ-003 SHALL have parameter AF_MARGIN, default 1, almostfull asserted when free entries <= AF_MARGIN (1..FIFO_DEPTH-1).
REQ-004 SHALL have parameter AE_MARGIN, default 1, almostempty asserted when occupancy <= AE_MARGIN (1..FIFO_DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port data_in  input  FIFO_WIDTH  write data.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port data_out  output  FIFO_WIDTH  registered read data.
REQ-011 SHALL have port rd_valid  output  1  registered, data_out updated by accepted read this cycle.
REQ-012 SHALL have port wr_ack  output  1  registered, previous-cycle write accepted.
REQ-013 SHALL have port overflow  output  1  registered, previous-cycle write rejected (full).
REQ-014 SHALL have port underflow  output  1  registered, previous-cycle read rejected (empty).
REQ-015 SHALL have ports full, empty, almostfull, almostempty  output  1 each  combinational status from count.
REQ-016 SHALL have port count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Function
REQ-017 SHALL accept a write iff wr_en=1 and full=0, storing data_in at wr_ptr; rd_en does not affect acceptance.
REQ-018 SHALL accept a read iff rd_en=1 and empty=0, loading mem[rd_ptr] into data_out one edge later (1-cycle read latency).
REQ-019 SHALL hold data_out when no read is accepted.
REQ-020 SHALL advance wr_ptr/rd_ptr by 1 per accepted write/read, wrapping FIFO_DEPTH-1 -> 0.
REQ-021 SHALL update count: +1 write only, -1 read only, unchanged when both or neither accepted.
REQ-022 SHALL, when full with wr_en=rd_en=1, perform read only (count -> DEPTH-1, overflow=1).
REQ-023 SHALL, when empty with wr_en=rd_en=1, perform write only (count -> 1, underflow=1, rd_valid=0).
REQ-024 SHALL drive full=(count==FIFO_DEPTH), empty=(count==0).
REQ-025 SHALL drive almostfull=(count>=FIFO_DEPTH-AF_MARGIN) and count<FIFO_DEPTH.
REQ-026 SHALL drive almostempty=(count<=AE_MARGIN) and count>0.
REQ-027 SHALL set wr_ack/overflow/underflow/rd_valid for exactly one cycle per causing request, clearing otherwise.
REQ-028 SHALL never modify memory or pointers on rejected requests.
REQ-029 SHALL return words in strict write order across pointer wrap.

Reset
REQ-030 SHALL, on rst_n low, immediately clear wr_ptr, rd_ptr, count, data_out, rd_valid, wr_ack, overflow, underflow, independent of clk.
REQ-031 SHALL present empty=1, almostempty=0, full=0, almostfull=0 during and after reset.
REQ-032 SHALL not reset storage array; stale contents never readable since empty=1.
REQ-033 SHALL discard all contents on reset mid-operation; first post-reset read of written data returns first post-reset write.

Verification (WIDTH=16, DEPTH=8, margins 1)
REQ-034 SHALL pass: reset, write 0x0001..0x0008 -> wr_ack each cycle, count 1..8, almostfull at count 7, full at 8; 9th write 0xDEAD -> overflow=1, wr_ack=0, count stays 8.
REQ-035 SHALL pass: from full, read 8 times -> data_out 0x0001..0x0008 one cycle after each rd_en, rd_valid=1, almostempty at count 1, empty at 0; 9th read -> underflow=1, data_out holds 0x0008.
REQ-036 SHALL pass: count=4, wr_en=rd_en=1 for 20 cycles with incrementing data -> count stays 4, in-order output across multiple wraps.
REQ-037 SHALL pass: empty, wr_en=rd_en=1 with 0x00AA -> underflow=1, wr_ack=1, count=1; next read returns 0x00AA.
REQ-038 SHALL pass: count=5, rst_n pulsed low mid-cycle -> count=0, empty=1, flags 0 before next edge; write 0x1234 then read returns 0x1234.
